// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with a two-entry skid buffer and synchronous flush.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int PC_W   = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state;
    entry_t main_q, skid_q, in_e;
    logic   acc, pop;

    assign in_e     = '{ctrl: in_ctrl, pc: in_pc, data: in_data};
    assign acc      = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_ctrl = main_q.ctrl;
    assign out_pc   = main_q.pc;
    assign out_data = main_q.data;

    // main_q always drives the outputs; skid_q only catches the one entry
    // that was already in flight when out_ready dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            main_q.ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_q    <= in_e;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        skid_q   <= in_e;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (acc && pop) begin
                        main_q <= in_e;
                    end else if (pop) begin
                        state       <= EMPTY;
                        out_valid   <= 1'b0;
                        main_q.ctrl <= '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready    <= 1'b1;
                    out_valid   <= 1'b0;
                    main_q.ctrl <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Saturating counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if (!out_valid && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register for the processor datapath. It generalises the fixed inter-stage latch (ID/EX, EX/MEM, MEM/WB) with configurable widths, a valid/ready handshake, a two-entry skid buffer for full-throughput back-pressure, and synchronous flush that turns the stage into a bubble. Every instance sits between two adjacent pipeline stages and drives the downstream stage from registers only.

## Interface
- `CTRL_W`, default 8: packed control field (WB/M/EX bits); forced to zero when the stage holds a bubble.
- `PC_W`, default 8: program-counter field width.
- `DATA_W`, default 128: packed payload (instruction, operands, sign-extend, register indices).
- `CNT_W`, default 16: performance-counter width, used only with the macro.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `flush`, input, 1: synchronous squash of all held entries.
- `in_valid`, input, 1: upstream offers an entry.
- `in_ready`, output, 1: stage can accept; registered.
- `in_ctrl` / `in_pc` / `in_data`, input, CTRL_W / PC_W / DATA_W: upstream entry.
- `out_valid`, output, 1: downstream entry present; registered.
- `out_ready`, input, 1: downstream consumes the entry.
- `out_ctrl` / `out_pc` / `out_data`, output, CTRL_W / PC_W / DATA_W: held entry; registered.
- `stall_cnt`, `bubble_cnt`, output, CNT_W: counters, present only under the macro.

## Operation
- Input transfer `acc` = `in_valid & in_ready`. Output transfer `pop` = `out_valid & out_ready`.
- Storage: main register (drives outputs) and skid register. State is EMPTY, ONE (main full) or TWO (main and skid full).
- EMPTY: `acc` goes to ONE, with main loaded from the inputs.
- ONE with `acc` and no `pop`: goes to TWO, with skid loaded. ONE with `acc` and `pop`: stays in ONE, with main reloaded from the inputs. ONE with `pop` only: goes to EMPTY. ONE otherwise: holds.
- TWO with `pop`: goes to ONE, with skid copied to main. TWO otherwise: holds. `acc` cannot occur in TWO because `in_ready` is 0.
- `in_ready` next value is 1 unless the next state is TWO.
- `out_valid` is 1 in ONE and TWO, and 0 in EMPTY.
- `out_ctrl` is all-zero whenever `out_valid` is 0 (bubble).
- `out_pc` and `out_data` hold their last values in EMPTY, except after `rst`, when they are zero.
- `flush` takes priority over all transfers:
  - next state is EMPTY; `out_valid` is 0, `out_ctrl` is 0 and `in_ready` is 1 on the next cycle;
  - any `acc` or `pop` in the flush cycle is discarded, and the upstream entry is lost.
- `rst` takes priority over `flush`.
- No combinational path exists from any input to any output.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - state EMPTY, `in_ready` 1, `out_valid` 0;
  - `out_ctrl`, `out_pc` and `out_data` all 0;
  - counters 0.
- Reset mid-operation discards both entries identically.
- Latency: an entry accepted at edge N is visible on the outputs after edge N with `out_valid` 1, which is one cycle.
- Throughput: one entry per cycle while `out_ready` is 1.
- Back-pressure: after `out_ready` drops, exactly one further entry is absorbed into the skid. `in_ready` is 0 from the following cycle.
- Recovery: `in_ready` returns to 1 one cycle after the `pop` that leaves TWO.
- Ordering is strict FIFO: the skid entry always follows the main entry.

## Configuration
- Macro: `PIPE_STAGE_PERF_EN`.
- Defined: `stall_cnt` and `bubble_cnt` ports exist.
  - `stall_cnt` increments each cycle with `out_valid & ~out_ready`.
  - `bubble_cnt` increments each cycle with `~out_valid`.
  - Both counters saturate at all-ones and are cleared only by `rst`; `flush` does not clear them.
- Undefined: the ports and counter logic are absent. Handshake behaviour is identical in both builds.

## Test plan
- Reset, then `in_valid` high with `in_ctrl`=8'hA5 and `in_pc`=8'h10, and `out_ready` held high. Required: `out_valid`=1 and `out_ctrl`=8'hA5 one cycle later, and entries stream 1 per cycle.
- Stream pc 1, 2, 3, 4, dropping `out_ready` after pc 1 is output. Required: pc 2 sits in main and pc 3 in skid, `in_ready`=0; after raising `out_ready`, outputs are 2, 3, 4 in order with no loss or duplicate.
- Stage in state TWO, pulse `flush` while `in_valid`=1. Required: next cycle `out_valid`=0, `out_ctrl`=0 and `in_ready`=1, and the flushed input never appears.
- Assert `rst` and `flush` together while in state ONE. Required: all outputs zero and `in_ready`=1.
- With `PIPE_STAGE_PERF_EN` and `CNT_W`=4: 20 cycles with `out_valid` high and `out_ready` low, then idle. Required: `stall_cnt`=4'hF (saturated) and `bubble_cnt` counting the idle cycles.
